// File: rtl/key8_onehot_capture_if.sv
// Event handshake bundle between key8_onehot_capture and its consumer.
// The master drives a one-hot event with valid; the slave returns ready.
interface key8_onehot_capture_if;
  logic [7:0] key_onehot;
  logic       key_valid;
  logic       key_ready;

  modport master (
    output key_onehot,
    output key_valid,
    input  key_ready
  );

  modport slave (
    input  key_onehot,
    input  key_valid,
    output key_ready
  );
endinterface

// File: rtl/key8_onehot_capture.sv
// Eight-channel debouncer feeding a one-hot press-event queue.
// Define KEY8_SYNC2_EN to add a two-flop input synchroniser.
module key8_onehot_capture #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            raw_in,
  key8_onehot_capture_if.master key_if,
  output logic [7:0]            key_level,
  output logic                  overflow
);

  typedef enum logic {
    IDLE,
    PRESENT
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [7:0] s;

`ifdef KEY8_SYNC2_EN
  logic [7:0] sync1_q;
  logic [7:0] sync2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= raw_in;
      sync2_q <= sync1_q;
    end
  end

  assign s = sync2_q;
`else
  assign s = raw_in;
`endif

  logic [CNT_W-1:0] cnt_q [8];
  logic [CNT_W-1:0] cnt_d [8];
  logic [7:0]       level_q;
  logic [7:0]       level_d;
  logic [7:0]       rise;
  logic [7:0]       pending_q;
  logic [7:0]       pending_d;
  logic [7:0]       sel;
  logic [7:0]       clr;
  logic             ovf_q;
  logic             ovf_d;
  logic [7:0]       onehot_q;
  logic             valid_q;
  state_t           state_q;

  // Counter saturates at CNT_MAX; any agreeing sample restarts it.
  always_comb begin
    level_d = level_q;
    rise    = '0;
    for (int i = 0; i < 8; i++) begin
      cnt_d[i] = '0;
      if (s[i] != level_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          level_d[i] = s[i];
          rise[i]    = s[i];
        end else begin
          cnt_d[i] = cnt_q[i] + CNT_W'(1);
        end
      end
    end
  end

  // Highest pending index wins, matching the downstream encoder.
  always_comb begin
    sel = '0;
    for (int i = 0; i < 8; i++) begin
      if (pending_q[i]) begin
        sel    = '0;
        sel[i] = 1'b1;
      end
    end
  end

  assign clr       = (state_q == IDLE) ? sel : '0;
  assign pending_d = (pending_q & ~clr) | rise;
  assign ovf_d     = |(rise & pending_q & ~clr);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= '0;
      end
      level_q   <= '0;
      pending_q <= '0;
      ovf_q     <= 1'b0;
      onehot_q  <= '0;
      valid_q   <= 1'b0;
      state_q   <= IDLE;
    end else begin
      for (int i = 0; i < 8; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
      level_q   <= level_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      unique case (state_q)
        IDLE: begin
          if (|pending_q) begin
            onehot_q <= sel;
            valid_q  <= 1'b1;
            state_q  <= PRESENT;
          end
        end
        PRESENT: begin
          if (key_if.key_ready) begin
            onehot_q <= '0;
            valid_q  <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          onehot_q <= '0;
          valid_q  <= 1'b0;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign key_if.key_onehot = onehot_q;
  assign key_if.key_valid  = valid_q;
  assign key_level         = level_q;
  assign overflow          = ovf_q;

endmodule

// File: tb/tb_key8_onehot_capture.sv
// Scoreboard bench for key8_onehot_capture with DEBOUNCE_CYCLES=4.
// Expected events are queued by stimulus and popped by a monitor.
module tb_key8_onehot_capture;

`ifdef KEY8_SYNC2_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] raw_in;
  logic [7:0] key_level;
  logic       overflow;

  key8_onehot_capture_if kif ();

  key8_onehot_capture #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (16)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .raw_in   (raw_in),
    .key_if   (kif.master),
    .key_level(key_level),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int ovf_cnt  = 0;
  logic [7:0] expq [$];

  task automatic chk(input string n,
                     input logic [31:0] act,
                     input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, req);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_valid(input string n);
    int cnt;
    cnt = 0;
    while (kif.key_valid !== 1'b1 && cnt < 50) begin
      tick();
      cnt++;
    end
    chk(n, {31'd0, kif.key_valid}, 32'd1);
  endtask

  // Monitor: one-hot invariant, overflow count, event scoreboard.
  always @(negedge clk) begin
    if (!rst) begin
      if (overflow === 1'b1) ovf_cnt++;
      if (kif.key_valid === 1'b1) begin
        if (!$onehot(kif.key_onehot)) begin
          checks++;
          failures++;
          $display("FAIL onehot: got %0h not one-hot", kif.key_onehot);
        end
        if (kif.key_ready === 1'b1) begin
          checks++;
          if (expq.size() == 0) begin
            failures++;
            $display("FAIL event: got %0h expected none",
                     kif.key_onehot);
          end else begin
            logic [7:0] e;
            e = expq.pop_front();
            if (kif.key_onehot !== e) begin
              failures++;
              $display("FAIL event: got %0h expected %0h",
                       kif.key_onehot, e);
            end
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    raw_in = 8'h00;
    kif.key_ready = 1'b0;
    tick(2);
    chk("rst_valid", {31'd0, kif.key_valid}, 32'd0);
    chk("rst_onehot", {24'd0, kif.key_onehot}, 32'd0);
    chk("rst_level", {24'd0, key_level}, 32'd0);
    chk("rst_ovf", {31'd0, overflow}, 32'd0);

    // Single clean press: raw applied before edge 1.
    rst = 1'b0;
    kif.key_ready = 1'b1;
    raw_in = 8'h04;
    expq.push_back(8'h04);
    tick(3 + LAT);
    chk("s1_level_early", {24'd0, key_level}, 32'h00);
    tick();
    chk("s1_level", {24'd0, key_level}, 32'h04);
    chk("s1_valid_early", {31'd0, kif.key_valid}, 32'd0);
    tick();
    chk("s1_valid", {31'd0, kif.key_valid}, 32'd1);
    chk("s1_onehot", {24'd0, kif.key_onehot}, 32'h04);
    tick();
    chk("s1_valid_drop", {31'd0, kif.key_valid}, 32'd0);
    raw_in = 8'h00;
    tick(8 + LAT);
    chk("s1_level_rel", {24'd0, key_level}, 32'h00);
    chk("s1_drain", expq.size(), 0);

    // Bounce rejection: 1,1,1,0 never reaches four differing samples.
    for (int r = 0; r < 5; r++) begin
      raw_in = 8'h01; tick(3);
      raw_in = 8'h00; tick(1);
    end
    tick(4 + LAT);
    chk("bounce_level", {24'd0, key_level}, 32'h00);
    chk("bounce_novalid", {31'd0, kif.key_valid}, 32'd0);
    expq.push_back(8'h01);
    raw_in = 8'h01;
    tick(4 + LAT);
    chk("bounce_hold_level", {24'd0, key_level}, 32'h01);
    raw_in = 8'h00;
    tick(8 + LAT);
    chk("bounce_drain", expq.size(), 0);

    // Simultaneous presses, consumer stalled for 10 cycles.
    kif.key_ready = 1'b0;
    raw_in = 8'h81;
    expq.push_back(8'h80);
    expq.push_back(8'h01);
    wait_valid("sim_wait");
    chk("sim_first", {24'd0, kif.key_onehot}, 32'h80);
    for (int c = 0; c < 10; c++) begin
      tick();
      chk("sim_hold",
          {23'd0, kif.key_valid, kif.key_onehot}, 32'h180);
    end
    kif.key_ready = 1'b1;
    tick(6);
    chk("sim_drain", expq.size(), 0);
    raw_in = 8'h00;
    tick(8 + LAT);
    chk("sim_ovf_none", ovf_cnt, 0);

    // Overflow: key 3 pressed twice while key 5 is being presented.
    kif.key_ready = 1'b0;
    ovf_cnt = 0;
    raw_in = 8'h20;
    expq.push_back(8'h20);
    expq.push_back(8'h08);
    wait_valid("ovf_wait");
    chk("ovf_present", {24'd0, kif.key_onehot}, 32'h20);
    raw_in = 8'h28; tick(6);
    chk("ovf_press1", ovf_cnt, 0);
    raw_in = 8'h20; tick(6);
    chk("ovf_rel_level", {24'd0, key_level}, 32'h20);
    raw_in = 8'h28; tick(6);
    chk("ovf_pulse", ovf_cnt, 1);
    kif.key_ready = 1'b1;
    tick(8);
    chk("ovf_drain", expq.size(), 0);
    raw_in = 8'h00;
    tick(10 + LAT);

    // Reset while presenting key 3 with keys 2..0 pending.
    kif.key_ready = 1'b0;
    raw_in = 8'h0F;
    wait_valid("rst_mid_wait");
    chk("rst_mid_present", {24'd0, kif.key_onehot}, 32'h08);
    rst = 1'b1;
    raw_in = 8'h00;
    tick();
    rst = 1'b0;
    chk("rst_mid_valid", {31'd0, kif.key_valid}, 32'd0);
    chk("rst_mid_onehot", {24'd0, kif.key_onehot}, 32'h00);
    chk("rst_mid_level", {24'd0, key_level}, 32'h00);
    chk("rst_mid_ovf", {31'd0, overflow}, 32'd0);
    kif.key_ready = 1'b1;
    tick(20);
    chk("rst_mid_stale", {31'd0, kif.key_valid}, 32'd0);
    chk("final_drain", expq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/key8_onehot_capture.md
# key8_onehot_capture

- Debounces eight raw push-button/switch inputs and turns each debounced press (0→1) into a queued event.
- Presents one event at a time as a strictly one-hot 8-bit vector with a valid/ready handshake.
- Sits directly upstream of the 8-to-3 encoder: `key_onehot` drives the encoder's 8-bit input, so the encoder never sees zero-hot or multi-hot codes while `key_valid` is high.

## Interface
- `DEBOUNCE_CYCLES`, default 16: consecutive differing samples required before a channel's stable value flips. Legal range is 2..65535.
- `CNT_W`, default 16: width of each debounce counter. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.
- `clk`  in  1: single clock. All flops are rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `raw_in`  in  8: asynchronous raw key levels, active-high.
- `key_onehot`  out  8: current event, one-hot. Bit i means key i.
- `key_valid`  out  1: `key_onehot` holds an unconsumed event.
- `key_ready`  in  1: consumer accepts the event on `key_valid & key_ready`.
- `key_level`  out  8: debounced stable level of each key.
- `overflow`  out  1: one-cycle pulse when a press is dropped because that key already had an event pending.

## Operation
**Reset.** While `rst` is high at a clock edge:
- `key_onehot`=0, `key_valid`=0, `key_level`=0, `overflow`=0.
- All debounce counters and the pending bits are cleared.
- The FSM goes to IDLE.
- Reset in the middle of an operation discards any in-flight event and any pending events.

**Debounce, per channel i, on the sample `s[i]`:**
- If `s[i]` equals `key_level[i]`: counter ← 0.
- If they differ and counter < DEBOUNCE_CYCLES−1: counter +1.
- If they differ and counter = DEBOUNCE_CYCLES−1: `key_level[i]` ← `s[i]` and counter ← 0.
- The counter therefore never wraps. Any bounce back to the stable value restarts the count.

**Pending register (8 bits).**
- Set: `pending[i]` is set in the same cycle that `key_level[i]` flips 0→1.
- Release: a 1→0 flip creates no event.
- Overflow: if `pending[i]` is already 1 when a new press arrives, `overflow` pulses for one cycle and the press is dropped.
- Overflow does not apply while key i is in flight in PRESENT. That slot is free, so the new press is queued.
- Set beats clear: if the FSM is clearing `pending[i]` in the same cycle that a new press on i arrives, `pending[i]` ends at 1 and there is no overflow.

**Output FSM.**
- IDLE, `pending` = 0: stay in IDLE; `key_valid`=0, `key_onehot`=0.
- IDLE, `pending` ≠ 0:
  - select the highest set index j (same priority as the downstream encoder);
  - `key_onehot` ← 1<<j, `key_valid` ← 1;
  - clear `pending[j]`;
  - go to PRESENT.
- PRESENT, `key_ready`=0: hold. `key_onehot` and `key_valid` are stable.
- PRESENT, `key_ready`=1: `key_valid` ← 0, `key_onehot` ← 0, go to IDLE.
- There is a guaranteed one-cycle bubble between consecutive events.
- `key_ready` is ignored in IDLE.

## Timing
Let D = DEBOUNCE_CYCLES. A raw 0→1 change is applied before edge 1 and held clean.
- Macro off: the first differing sample is taken at edge 1 (plus the synchroniser delay when the macro is on). `key_level[i]` and `pending[i]` rise at edge D. `key_valid` rises at edge D+1.
- Macro on: both points shift by 2 cycles.
- Sustained throughput is at most one event per 2 cycles.
- All outputs are registered. There are no combinational paths from input to output.

## Configuration
Macro `KEY8_SYNC2_EN`.
- Defined: each `raw_in` bit passes through a two-flop synchroniser (reset to 0) before debounce, and `s` is the second flop. This adds 2 cycles of latency.
- Undefined: `s` = `raw_in` directly. This is for inputs that are already synchronous, and for simulation.
- Functional behaviour is otherwise identical in both cases.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, with the macro undefined unless stated.
- **Single clean press.** `raw_in`=8'h04 from edge 1 with `key_ready`=1:
  - `key_level`=8'h04 at edge 4;
  - `key_valid`=1 with `key_onehot`=8'h04 after edge 5;
  - `key_valid`=0 after edge 6.
- **Bounce rejection.** `raw_in[0]` toggles 1,1,1,0 repeatedly:
  - `key_level` stays 0 and `key_valid` is never asserted;
  - holding 1 for 4 samples then produces event 8'h01.
- **Simultaneous presses.** `raw_in`=8'h81 held, with `key_ready` low for 10 cycles and then high:
  - first event 8'h80, held stable while not ready;
  - second event 8'h01;
  - `key_onehot` is never multi-hot.
- **Overflow.** Key 3 is pressed, released and pressed again while `key_ready`=0 and key 5 is being presented:
  - `overflow` pulses once, on the second 0→1 `key_level[3]` flip;
  - after readying, exactly one 8'h08 event follows 8'h20.
- **Reset mid-operation.** Assert `rst` for 1 cycle while in PRESENT with 3 bits pending:
  - all outputs are 0 the next cycle;
  - no stale events appear afterwards.
- **Macro on.** Repeat the single clean press with `KEY8_SYNC2_EN` defined: `key_valid` rises after edge 7.
